// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline constants: ExcCode values, nop encoding and default handler vector.
package mips_pipe_pkg;

  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned WORD_W     = 32;

  localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

  localparam logic [WORD_W-1:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with prioritised req / stall / flush / load and a stall counter.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       EXC_W         = 5,
  parameter int unsigned       CNT_W         = 8,
  parameter logic [DATA_W-1:0] RESET_PC      = 32'h0000_0000,
  parameter logic [DATA_W-1:0] HANDLER_PC    = DEFAULT_HANDLER_PC,
  parameter bit                FLUSH_KEEP_PC = 1'b1,
  parameter bit                CHECK_PC      = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic              bd_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic              bd_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             hold_c;
  logic [EXC_W-1:0] load_exc_c;

  // Upstream exceptions always survive; alignment tagging only fills an empty code.
  always_comb begin
    load_exc_c = exc_in;
    if (CHECK_PC && valid_in && (exc_in == EXC_W'(EXC_NONE)) && (pc_in[1:0] != 2'b00)) begin
      load_exc_c = EXC_W'(EXC_ADEL);
    end
  end

  assign hold_c = stall && !req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      instr_out <= DATA_W'(NOP_INSTR);
      pc_out    <= RESET_PC;
      exc_out   <= EXC_W'(EXC_NONE);
      bd_out    <= 1'b0;
    end else if (req) begin
      valid_out <= 1'b0;
      instr_out <= DATA_W'(NOP_INSTR);
      pc_out    <= HANDLER_PC;
      exc_out   <= EXC_W'(EXC_NONE);
      bd_out    <= 1'b0;
    end else if (stall) begin
      valid_out <= valid_out;
    end else if (flush) begin
      valid_out <= 1'b0;
      instr_out <= DATA_W'(NOP_INSTR);
      exc_out   <= EXC_W'(EXC_NONE);
      pc_out    <= FLUSH_KEEP_PC ? pc_in : '0;
      bd_out    <= FLUSH_KEEP_PC ? bd_in : 1'b0;
    end else begin
      valid_out <= valid_in;
      instr_out <= instr_in;
      pc_out    <= pc_in;
      exc_out   <= load_exc_c;
      bd_out    <= bd_in;
    end
  end

  // Any edge where stall does not win clears the run length.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (hold_c),
    .clr  (!hold_c),
    .cnt  (stall_cnt)
  );

endmodule
